// File: rtl/multicycle_seq_if.sv
// Handshake and strobe bundle between the multi-cycle sequencer and the RV32I datapath.
// Latency: none, wires only.
// Backpressure: if_ack_i, alu_done_i and mem_ack_i hold the sequencer in place until asserted.
//
// Port summary (master = sequencer side, slave = datapath side):
//   fetch   : if_req_o (out), if_ack_i (in), ir_we_o (out)
//   decode  : dec_illegal_i, dec_alu_multi_i, dec_mem_rd_i, dec_mem_wr_i,
//             dec_reg_wr_i, dec_pc_sel_i (all in)
//   alu     : alu_start_o (out), alu_done_i (in)
//   ram     : mem_req_o, mem_rd_o, mem_wr_o (out), mem_ack_i (in)
//   wb / pc : reg_we_o, pc_we_o, pc_sel_o (out)
interface multicycle_seq_if;
  // fetch
  logic if_req_o;
  logic if_ack_i;
  logic ir_we_o;
  // decoder controls, held stable by the decoder for the whole instruction
  logic dec_illegal_i;
  logic dec_alu_multi_i;
  logic dec_mem_rd_i;
  logic dec_mem_wr_i;
  logic dec_reg_wr_i;
  logic dec_pc_sel_i;
  // multi-cycle ALU
  logic alu_start_o;
  logic alu_done_i;
  // data RAM
  logic mem_req_o;
  logic mem_rd_o;
  logic mem_wr_o;
  logic mem_ack_i;
  // writeback and PC
  logic reg_we_o;
  logic pc_we_o;
  logic pc_sel_o;

  modport master (
    output if_req_o, ir_we_o, alu_start_o,
    output mem_req_o, mem_rd_o, mem_wr_o,
    output reg_we_o, pc_we_o, pc_sel_o,
    input  if_ack_i, alu_done_i, mem_ack_i,
    input  dec_illegal_i, dec_alu_multi_i, dec_mem_rd_i,
    input  dec_mem_wr_i, dec_reg_wr_i, dec_pc_sel_i
  );

  modport slave (
    input  if_req_o, ir_we_o, alu_start_o,
    input  mem_req_o, mem_rd_o, mem_wr_o,
    input  reg_we_o, pc_we_o, pc_sel_o,
    output if_ack_i, alu_done_i, mem_ack_i,
    output dec_illegal_i, dec_alu_multi_i, dec_mem_rd_i,
    output dec_mem_wr_i, dec_reg_wr_i, dec_pc_sel_i
  );
endinterface

// File: rtl/multicycle_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core with debug run/step control.
// Latency: min 4 cycles per instruction (F,D,E,W), +1 per ALU wait cycle, +1 per MEM cycle.
// Backpressure: stalls in FETCH/EXEC/MEM until the ack/done arrives; FETCH/MEM time out to FAULT.
//
// Port summary:
//   clk, rst       : core clock, synchronous active-high reset
//   run_i, step_i  : free-run level, single-step pulse (only honoured in IDLE)
//   bus            : handshake/strobe bundle (multicycle_seq_if.master)
//   halt_o         : core stopped (IDLE or FAULT)
//   state_o        : IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 FAULT=6
//   fault_o        : sticky fault flag, cleared only by rst
//   fault_code_o   : 01 fetch timeout, 10 mem timeout, 11 illegal instruction
//   cycle_o        : cycles spent in FETCH..WB
//   instret_o      : retired instructions
module multicycle_seq #(
  parameter int ACK_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_i,
  input  logic              step_i,
  multicycle_seq_if.master  bus,
  output logic              halt_o,
  output logic [2:0]        state_o,
  output logic              fault_o,
  output logic [1:0]        fault_code_o,
  output logic [CNT_W-1:0]  cycle_o,
  output logic [CNT_W-1:0]  instret_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_FETCH = 2'b01;
  localparam logic [1:0] FC_MEM   = 2'b10;
  localparam logic [1:0] FC_ILL   = 2'b11;

  // The timeout counter holds the number of ack-less cycles already spent
  // in the current FETCH/MEM visit, so the visit's last permitted cycle is
  // the one where the counter equals ACK_TIMEOUT-1.
  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);
  localparam logic [7:0] TMO_MAX  = 8'hFF;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             step_mode_q, step_mode_d;
  logic             alu_start_q, alu_start_d;
  logic [1:0]       fault_code_q, fault_code_d;
  logic [7:0]       tmo_q, tmo_d;
  logic             tmo_hit;
  logic             cnt_active;
  logic [CNT_W-1:0] cycle_q, instret_q;

  assign tmo_hit = (tmo_q >= TMO_LAST);

  // ------------------------------------------------------------------
  // Next state and strobes
  // ------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    step_mode_d  = step_mode_q;
    fault_code_d = fault_code_q;
    alu_start_d  = 1'b0;

    bus.if_req_o  = 1'b0;
    bus.ir_we_o   = 1'b0;
    bus.mem_req_o = 1'b0;
    bus.mem_rd_o  = 1'b0;
    bus.mem_wr_o  = 1'b0;
    bus.reg_we_o  = 1'b0;
    bus.pc_we_o   = 1'b0;
    bus.pc_sel_o  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // run has priority; a step only arms single-instruction mode
        if (run_i) begin
          state_d = S_FETCH;
        end else if (step_i) begin
          state_d     = S_FETCH;
          step_mode_d = 1'b1;
        end
      end

      S_FETCH: begin
        bus.if_req_o = 1'b1;
        if (bus.if_ack_i) begin
          bus.ir_we_o = 1'b1;
          state_d     = S_DECODE;
        end else if (tmo_hit) begin
          state_d      = S_FAULT;
          fault_code_d = FC_FETCH;
        end
      end

      S_DECODE: begin
        if (bus.dec_illegal_i) begin
          state_d      = S_FAULT;
          fault_code_d = FC_ILL;
        end else begin
          state_d     = S_EXEC;
          alu_start_d = bus.dec_alu_multi_i;
        end
      end

      S_EXEC: begin
        // a done coincident with the start pulse is accepted
        if (!bus.dec_alu_multi_i || bus.alu_done_i) begin
          if (bus.dec_mem_rd_i || bus.dec_mem_wr_i) begin
            state_d = S_MEM;
          end else begin
            state_d = S_WB;
          end
        end
      end

      S_MEM: begin
        bus.mem_req_o = 1'b1;
        bus.mem_rd_o  = bus.dec_mem_rd_i;
        // a decode claiming both load and store is treated as a load
        bus.mem_wr_o  = bus.dec_mem_wr_i & ~bus.dec_mem_rd_i;
        if (bus.mem_ack_i) begin
          state_d = S_WB;
        end else if (tmo_hit) begin
          state_d      = S_FAULT;
          fault_code_d = FC_MEM;
        end
      end

      S_WB: begin
        bus.reg_we_o = bus.dec_reg_wr_i;
        bus.pc_we_o  = 1'b1;
        bus.pc_sel_o = bus.dec_pc_sel_i;
        step_mode_d  = 1'b0;
        if (run_i && !step_mode_q) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_FAULT: begin
        state_d = S_FAULT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Ack timeout counter: restarts on every entry to FETCH or MEM
  // ------------------------------------------------------------------
  always_comb begin
    tmo_d = tmo_q;
    if ((state_d == S_FETCH || state_d == S_MEM) && (state_d != state_q)) begin
      tmo_d = 8'd0;
    end else if (((state_q == S_FETCH) && !bus.if_ack_i) ||
                 ((state_q == S_MEM) && !bus.mem_ack_i)) begin
      if (tmo_q != TMO_MAX) begin
        tmo_d = tmo_q + 8'd1;
      end
    end
  end

  assign cnt_active = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                      (state_q == S_EXEC)  || (state_q == S_MEM)    ||
                      (state_q == S_WB);

  // ------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      step_mode_q  <= 1'b0;
      alu_start_q  <= 1'b0;
      fault_code_q <= FC_NONE;
      tmo_q        <= 8'd0;
      cycle_q      <= '0;
      instret_q    <= '0;
    end else begin
      state_q      <= state_d;
      step_mode_q  <= step_mode_d;
      alu_start_q  <= alu_start_d;
      fault_code_q <= fault_code_d;
      tmo_q        <= tmo_d;
      if (cnt_active) begin
        cycle_q <= cycle_q + CNT_ONE;
      end
      if (state_q == S_WB) begin
        instret_q <= instret_q + CNT_ONE;
      end
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  // registered so the ALU sees a clean one-cycle pulse in the first EXEC cycle
  assign bus.alu_start_o = alu_start_q;

  assign halt_o       = (state_q == S_IDLE) || (state_q == S_FAULT);
  assign state_o      = state_q;
  assign fault_o      = (state_q == S_FAULT);
  assign fault_code_o = fault_code_q;
  assign cycle_o      = cycle_q;
  assign instret_o    = instret_q;

endmodule

// File: tb/tb_multicycle_seq.sv
// Directed self-checking bench for multicycle_seq (CNT_W=4 so counter wrap is reachable).
// Latency: n/a.
// Backpressure: acks/done driven per scenario, every wait bounded.
module tb_multicycle_seq;

  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          run_i;
  logic          step_i;
  logic          halt_o;
  logic [2:0]    state_o;
  logic          fault_o;
  logic [1:0]    fault_code_o;
  logic [CW-1:0] cycle_o;
  logic [CW-1:0] instret_o;

  int checks   = 0;
  int failures = 0;

  multicycle_seq_if bus();

  multicycle_seq #(
    .ACK_TIMEOUT (15),
    .CNT_W       (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .run_i        (run_i),
    .step_i       (step_i),
    .bus          (bus),
    .halt_o       (halt_o),
    .state_o      (state_o),
    .fault_o      (fault_o),
    .fault_code_o (fault_code_o),
    .cycle_o      (cycle_o),
    .instret_o    (instret_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic clk_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    run_i               = 1'b0;
    step_i              = 1'b0;
    bus.if_ack_i        = 1'b0;
    bus.dec_illegal_i   = 1'b0;
    bus.dec_alu_multi_i = 1'b0;
    bus.dec_mem_rd_i    = 1'b0;
    bus.dec_mem_wr_i    = 1'b0;
    bus.dec_reg_wr_i    = 1'b0;
    bus.dec_pc_sel_i    = 1'b0;
    bus.alu_done_i      = 1'b0;
    bus.mem_ack_i       = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    clk_cycle();
    clk_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    // inputs active during reset must not leak onto strobes
    run_i = 1'b1; bus.if_ack_i = 1'b1; bus.mem_ack_i = 1'b1; bus.dec_reg_wr_i = 1'b1;
    clk_cycle();
    clk_cycle();
    #1;
    checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    checks++; if (halt_o !== 1'b1) begin failures++; $display("FAIL reset_halt got=%0b exp=1", halt_o); end
    checks++; if ({fault_o, fault_code_o} !== 3'b000) begin failures++; $display("FAIL reset_fault got=%b exp=000", {fault_o, fault_code_o}); end
    checks++; if ({cycle_o, instret_o} !== 8'h00) begin failures++; $display("FAIL reset_counters got=%h exp=00", {cycle_o, instret_o}); end
    checks++;
    if ({bus.if_req_o, bus.ir_we_o, bus.alu_start_o, bus.mem_req_o, bus.mem_rd_o,
         bus.mem_wr_o, bus.reg_we_o, bus.pc_we_o, bus.pc_sel_o} !== 9'b0) begin
      failures++; $display("FAIL reset_strobes got=%b exp=000000000",
        {bus.if_req_o, bus.ir_we_o, bus.alu_start_o, bus.mem_req_o, bus.mem_rd_o,
         bus.mem_wr_o, bus.reg_we_o, bus.pc_we_o, bus.pc_sel_o});
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_alu_instr();
    logic [2:0] exp_a [5];
    logic [2:0] exp_b [4];
    exp_a = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
    exp_b = '{3'd2, 3'd3, 3'd5, 3'd0};
    do_reset();
    run_i = 1'b1; bus.if_ack_i = 1'b1; bus.dec_reg_wr_i = 1'b1;
    clk_cycle();
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (state_o !== exp_a[i]) begin failures++; $display("FAIL alu_state[%0d] got=%0d exp=%0d", i, state_o, exp_a[i]); end
      checks++;
      if ({bus.ir_we_o, bus.reg_we_o, bus.pc_we_o} !== {exp_a[i] == 3'd1, exp_a[i] == 3'd5, exp_a[i] == 3'd5}) begin
        failures++; $display("FAIL alu_strobes[%0d] got=%b exp=%b", i, {bus.ir_we_o, bus.reg_we_o, bus.pc_we_o},
                             {exp_a[i] == 3'd1, exp_a[i] == 3'd5, exp_a[i] == 3'd5});
      end
      if (i == 4) begin
        checks++; if (cycle_o !== 4'd4) begin failures++; $display("FAIL alu_cycle_2nd_fetch got=%0d exp=4", cycle_o); end
        checks++; if (instret_o !== 4'd1) begin failures++; $display("FAIL alu_instret_1 got=%0d exp=1", instret_o); end
      end
      clk_cycle();
    end
    // run drops mid-instruction: it finishes through WB, then IDLE
    run_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (state_o !== exp_b[i]) begin failures++; $display("FAIL alu_drain_state[%0d] got=%0d exp=%0d", i, state_o, exp_b[i]); end
      if (i < 3) clk_cycle();
    end
    checks++; if ({instret_o, cycle_o} !== {4'd2, 4'd8}) begin failures++; $display("FAIL alu_drain_counters got=%h exp=28", {instret_o, cycle_o}); end
    checks++; if (halt_o !== 1'b1) begin failures++; $display("FAIL alu_drain_halt got=%0b exp=1", halt_o); end
  endtask

  task automatic test_load_store();
    int n;
    do_reset();
    run_i = 1'b1; bus.if_ack_i = 1'b1; bus.dec_mem_rd_i = 1'b1; bus.dec_reg_wr_i = 1'b1;
    n = 0;
    while (state_o !== 3'd4 && n < 20) begin clk_cycle(); n++; end
    checks++; if (state_o !== 3'd4) begin failures++; $display("FAIL load_reach_mem got=%0d exp=4", state_o); end
    for (int k = 1; k <= 4; k++) begin
      bus.mem_ack_i = (k == 4);
      #1;
      checks++;
      if ({state_o, bus.mem_req_o, bus.mem_rd_o, bus.mem_wr_o} !== {3'd4, 3'b110}) begin
        failures++; $display("FAIL load_mem_cyc%0d got=%b exp=100110", k, {state_o, bus.mem_req_o, bus.mem_rd_o, bus.mem_wr_o});
      end
      clk_cycle();
    end
    bus.mem_ack_i = 1'b0;
    #1;
    checks++; if ({state_o, bus.reg_we_o, bus.mem_req_o} !== {3'd5, 2'b10}) begin failures++; $display("FAIL load_wb got=%b exp=10110", {state_o, bus.reg_we_o, bus.mem_req_o}); end
    // next instruction claims both read and write: only the read goes out
    bus.dec_mem_wr_i = 1'b1;
    clk_cycle();
    n = 0;
    while (state_o !== 3'd4 && n < 20) begin clk_cycle(); n++; end
    bus.mem_ack_i = 1'b1;
    #1;
    checks++; if ({state_o, bus.mem_rd_o, bus.mem_wr_o} !== {3'd4, 2'b10}) begin failures++; $display("FAIL rdwr_suppress got=%b exp=10010", {state_o, bus.mem_rd_o, bus.mem_wr_o}); end
    clk_cycle();
    // plain store, no register write
    bus.dec_mem_rd_i = 1'b0; bus.dec_reg_wr_i = 1'b0;
    clk_cycle();
    n = 0;
    while (state_o !== 3'd4 && n < 20) begin clk_cycle(); n++; end
    #1;
    checks++; if ({state_o, bus.mem_rd_o, bus.mem_wr_o} !== {3'd4, 2'b01}) begin failures++; $display("FAIL store_strobes got=%b exp=10001", {state_o, bus.mem_rd_o, bus.mem_wr_o}); end
    clk_cycle();
    #1;
    checks++; if ({state_o, bus.reg_we_o} !== {3'd5, 1'b0}) begin failures++; $display("FAIL store_wb got=%b exp=1010", {state_o, bus.reg_we_o}); end
    run_i = 1'b0;
    clk_cycle();
    checks++; if ({state_o, instret_o} !== {3'd0, 4'd3}) begin failures++; $display("FAIL store_idle got=%h exp=03", {1'b0, state_o, instret_o}); end
  endtask

  task automatic test_timeout();
    int n;
    // RAM never acks: 15 MEM cycles then FAULT code 10
    do_reset();
    run_i = 1'b1; bus.if_ack_i = 1'b1; bus.dec_mem_wr_i = 1'b1;
    n = 0;
    while (state_o !== 3'd4 && n < 20) begin clk_cycle(); n++; end
    for (int k = 1; k <= 15; k++) begin
      #1;
      checks++; if ({state_o, fault_o} !== {3'd4, 1'b0}) begin failures++; $display("FAIL mem_tmo_wait%0d got=%b exp=1000", k, {state_o, fault_o}); end
      clk_cycle();
    end
    #1;
    checks++; if ({state_o, fault_o, fault_code_o, halt_o} !== {3'd6, 1'b1, 2'b10, 1'b1}) begin
      failures++; $display("FAIL mem_tmo_fault got=%b exp=1101101", {state_o, fault_o, fault_code_o, halt_o});
    end
    checks++; if ({bus.mem_req_o, bus.pc_we_o, bus.if_req_o} !== 3'b000) begin failures++; $display("FAIL mem_tmo_strobes got=%b exp=000", {bus.mem_req_o, bus.pc_we_o, bus.if_req_o}); end
    step_i = 1'b1;
    clk_cycle();
    clk_cycle();
    step_i = 1'b0;
    checks++; if ({state_o, fault_code_o} !== {3'd6, 2'b10}) begin failures++; $display("FAIL fault_sticky got=%b exp=11010", {state_o, fault_code_o}); end

    // ack in the 15th MEM cycle wins
    do_reset();
    run_i = 1'b1; bus.if_ack_i = 1'b1; bus.dec_mem_wr_i = 1'b1;
    n = 0;
    while (state_o !== 3'd4 && n < 20) begin clk_cycle(); n++; end
    for (int k = 1; k <= 15; k++) begin
      bus.mem_ack_i = (k == 15);
      clk_cycle();
    end
    bus.mem_ack_i = 1'b0;
    checks++; if ({state_o, fault_o} !== {3'd5, 1'b0}) begin failures++; $display("FAIL mem_ack_at_limit got=%b exp=1010", {state_o, fault_o}); end

    // ROM never acks: FAULT code 01
    do_reset();
    run_i = 1'b1;
    clk_cycle();
    for (int k = 1; k <= 15; k++) begin
      #1;
      checks++; if ({state_o, bus.if_req_o} !== {3'd1, 1'b1}) begin failures++; $display("FAIL fetch_tmo_wait%0d got=%b exp=0011", k, {state_o, bus.if_req_o}); end
      clk_cycle();
    end
    checks++; if ({state_o, fault_code_o} !== {3'd6, 2'b01}) begin failures++; $display("FAIL fetch_tmo_fault got=%b exp=11001", {state_o, fault_code_o}); end
  endtask

  task automatic test_step();
    int n;
    do_reset();
    bus.if_ack_i = 1'b1; bus.dec_reg_wr_i = 1'b1;
    for (int p = 1; p <= 2; p++) begin
      step_i = 1'b1;
      clk_cycle();
      step_i = 1'b0;
      n = 0;
      while (state_o !== 3'd0 && n < 20) begin clk_cycle(); n++; end
      clk_cycle();
      clk_cycle();
      checks++; if ({state_o, instret_o} !== {3'd0, 4'(p)}) begin failures++; $display("FAIL step_pulse%0d got=%h exp=%h", p, {1'b0, state_o, instret_o}, {4'd0, 4'(p)}); end
    end
    // run beats a simultaneous step, and a step held while running is ignored
    run_i = 1'b1; step_i = 1'b1;
    clk_cycle();
    n = 0;
    while (state_o !== 3'd5 && n < 20) begin clk_cycle(); n++; end
    clk_cycle();
    checks++; if (state_o !== 3'd1) begin failures++; $display("FAIL step_run_wins got=%0d exp=1", state_o); end
    run_i = 1'b0; step_i = 1'b0;
    n = 0;
    while (state_o !== 3'd0 && n < 20) begin clk_cycle(); n++; end
    checks++; if ({state_o, instret_o} !== {3'd0, 4'd4}) begin failures++; $display("FAIL step_run_drain got=%h exp=04", {1'b0, state_o, instret_o}); end
  endtask

  task automatic test_illegal();
    do_reset();
    run_i = 1'b1; bus.if_ack_i = 1'b1; bus.dec_illegal_i = 1'b1; bus.dec_alu_multi_i = 1'b1;
    clk_cycle();
    clk_cycle();
    clk_cycle();
    #1;
    checks++; if ({state_o, fault_o, fault_code_o, halt_o} !== {3'd6, 1'b1, 2'b11, 1'b1}) begin
      failures++; $display("FAIL illegal_fault got=%b exp=1101111", {state_o, fault_o, fault_code_o, halt_o});
    end
    checks++; if (bus.alu_start_o !== 1'b0) begin failures++; $display("FAIL illegal_no_alu_start got=%0b exp=0", bus.alu_start_o); end
    rst = 1'b1;
    clk_cycle();
    #1;
    checks++; if ({state_o, fault_o, fault_code_o, halt_o} !== {3'd0, 1'b0, 2'b00, 1'b1}) begin
      failures++; $display("FAIL illegal_rst_state got=%b exp=0000001", {state_o, fault_o, fault_code_o, halt_o});
    end
    checks++; if ({cycle_o, instret_o, bus.if_req_o, bus.ir_we_o} !== 10'b0) begin
      failures++; $display("FAIL illegal_rst_outputs got=%b exp=0", {cycle_o, instret_o, bus.if_req_o, bus.ir_we_o});
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_multi_alu();
    int lat [3];
    logic [CW-1:0] base;
    lat  = '{6, 6, 1};
    base = 4'd0;
    do_reset();
    run_i = 1'b1; bus.if_ack_i = 1'b1; bus.dec_alu_multi_i = 1'b1;
    bus.dec_pc_sel_i = 1'b1; bus.dec_reg_wr_i = 1'b1;
    clk_cycle();
    for (int ins = 0; ins < 3; ins++) begin
      #1;
      checks++; if ({state_o, cycle_o, bus.pc_sel_o} !== {3'd1, base, 1'b0}) begin
        failures++; $display("FAIL malu%0d_fetch got=%b exp=%b", ins, {state_o, cycle_o, bus.pc_sel_o}, {3'd1, base, 1'b0});
      end
      clk_cycle();
      #1;
      checks++; if ({state_o, bus.alu_start_o, bus.pc_sel_o} !== {3'd2, 2'b00}) begin
        failures++; $display("FAIL malu%0d_decode got=%b exp=01000", ins, {state_o, bus.alu_start_o, bus.pc_sel_o});
      end
      clk_cycle();
      if (ins == 2) run_i = 1'b0;
      for (int e = 1; e <= lat[ins]; e++) begin
        bus.alu_done_i = (e == lat[ins]);
        #1;
        checks++;
        if ({state_o, bus.alu_start_o, bus.pc_sel_o, cycle_o} !== {3'd3, e == 1, 1'b0, 4'(base + 4'd1 + 4'(e))}) begin
          failures++; $display("FAIL malu%0d_exec%0d got=%b exp=%b", ins, e, {state_o, bus.alu_start_o, bus.pc_sel_o, cycle_o},
                               {3'd3, e == 1, 1'b0, 4'(base + 4'd1 + 4'(e))});
        end
        clk_cycle();
      end
      bus.alu_done_i = 1'b0;
      #1;
      checks++; if ({state_o, bus.pc_sel_o, bus.pc_we_o, bus.reg_we_o} !== {3'd5, 3'b111}) begin
        failures++; $display("FAIL malu%0d_wb got=%b exp=101111", ins, {state_o, bus.pc_sel_o, bus.pc_we_o, bus.reg_we_o});
      end
      base = 4'(base + 4'd3 + 4'(lat[ins]));
      clk_cycle();
    end
    // 9 + 9 + 4 = 22 active cycles, wrapped in 4 bits to 6
    checks++; if ({state_o, cycle_o, instret_o} !== {3'd0, 4'd6, 4'd3}) begin
      failures++; $display("FAIL malu_final got=%b exp=00001100011", {state_o, cycle_o, instret_o});
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_alu_instr();
    test_load_store();
    test_timeout();
    test_step();
    test_illegal();
    test_multi_alu();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
